// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared states, grant encodings and default timing for the buzzer arbiter.
// The KEY state exists only when BUZZER_KEY_CLICK_EN is defined.
package buzzer_pkg;
   localparam int DEF_CLK_HZ     = 1024;
   localparam int DEF_LO_DIV     = 4;
   localparam int DEF_HI_DIV     = 2;
   localparam int DEF_BEEP_TICKS = 256;
   localparam int DEF_ALARM_SEC  = 20;
   localparam int DEF_KEY_TICKS  = 32;
   localparam logic [2:0] G_IDLE  = 3'b000;
   localparam logic [2:0] G_ALARM = 3'b100;
   localparam logic [2:0] G_CHIME = 3'b010;
   localparam logic [2:0] G_KEY   = 3'b001;
   typedef enum logic [2:0] {
      IDLE, ALARM, CH_ON, CH_OFF, CH_HI
`ifdef BUZZER_KEY_CLICK_EN
      , KEY
`endif
   } state_t;
endpackage

// File: rtl/buzzer_arbiter_tone_gen.sv
// tone_gen: square wave that starts high on enable and toggles every div cycles.
module tone_gen #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] div,
   output logic         out
);
   logic [W-1:0] cnt;
   logic         ph;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         ph  <= 1'b1;
      end else if (!en) begin
         cnt <= '0;
         ph  <= 1'b1;
      end else if (cnt >= div - 1'b1) begin
         cnt <= '0;
         ph  <= !ph;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
   assign out = en & ph;
endmodule

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: fixed-priority piezo sharing (alarm > chime > key) with tone sequencing.
// The key-click path is built only when BUZZER_KEY_CLICK_EN is defined.
module buzzer_arbiter
   import buzzer_pkg::*;
#(
   parameter int CLK_HZ     = DEF_CLK_HZ,
   parameter int LO_DIV     = DEF_LO_DIV,
   parameter int HI_DIV     = DEF_HI_DIV,
   parameter int BEEP_TICKS = DEF_BEEP_TICKS,
   parameter int ALARM_SEC  = DEF_ALARM_SEC,
   parameter int KEY_TICKS  = DEF_KEY_TICKS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       alarm_req,
   input  logic       chime_req,
   input  logic       key_req,
   input  logic       ack,
   output logic       buzz,
   output logic [2:0] grant,
   output logic       busy
);
   localparam int ALARM_CYC = ALARM_SEC * CLK_HZ;
   localparam int GATE      = CLK_HZ / 8;
   localparam int DUR_W     = $clog2(ALARM_CYC);
   localparam int DIV_W     = $clog2(LO_DIV > HI_DIV ? LO_DIV : HI_DIV) + 1;
   state_t           state, state_n;
   logic [DUR_W-1:0] dur;
   logic [1:0]       beep_cnt, beep_cnt_n;
   logic             silenced, silenced_n, ring, alarm_to, is_key, tone_en, is_chime;
   logic [DIV_W-1:0] div;
`ifdef BUZZER_KEY_CLICK_EN
   assign is_key = state == KEY;
`else
   logic unused_key;
   assign unused_key = key_req;
   assign is_key     = 1'b0;
`endif
   assign ring     = alarm_req && !silenced;
   assign alarm_to = state == ALARM && dur == DUR_W'(ALARM_CYC - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         dur      <= '0;
         beep_cnt <= '0;
         silenced <= 1'b0;
      end else begin
         state    <= state_n;
         dur      <= (state_n != state) ? '0 : dur + 1'b1;
         beep_cnt <= beep_cnt_n;
         silenced <= silenced_n;
      end
   end
   always_comb begin
      state_n    = state;
      beep_cnt_n = beep_cnt;
      silenced_n = !alarm_req ? 1'b0 : (state == ALARM && (ack || alarm_to)) ? 1'b1 : silenced;
      case (state)
         IDLE: begin
            if (ring) state_n = ALARM;
            else if (chime_req) begin
               state_n    = CH_ON;
               beep_cnt_n = '0;
            end
`ifdef BUZZER_KEY_CLICK_EN
            else if (key_req) state_n = KEY;
`endif
         end
         ALARM:  if (!alarm_req || ack || alarm_to) state_n = IDLE;
         CH_ON:  if (dur == DUR_W'(BEEP_TICKS - 1)) state_n = CH_OFF;
         CH_OFF: begin
            if (dur == DUR_W'(CLK_HZ - BEEP_TICKS - 1)) begin
               state_n    = (beep_cnt == 2'd3) ? CH_HI : CH_ON;
               beep_cnt_n = beep_cnt + 1'b1;
            end
         end
         CH_HI:  if (dur == DUR_W'(CLK_HZ - 1)) state_n = IDLE;
`ifdef BUZZER_KEY_CLICK_EN
         KEY:    if (dur == DUR_W'(KEY_TICKS - 1)) state_n = IDLE;
`endif
         default: state_n = IDLE;
      endcase
      // an alarm abandons whatever lower-priority pattern is playing
      if (state != IDLE && state != ALARM && ring) state_n = ALARM;
   end
   always_comb begin
      is_chime = state == CH_ON || state == CH_OFF || state == CH_HI;
      grant    = state == ALARM ? G_ALARM : is_chime ? G_CHIME : is_key ? G_KEY : G_IDLE;
      busy     = grant != G_IDLE;
      tone_en  = (state == ALARM && ((int'(dur) / GATE) % 2) == 0) || state == CH_ON ||
                 state == CH_HI || is_key;
      div      = state == CH_ON ? DIV_W'(LO_DIV) : DIV_W'(HI_DIV);
   end
   tone_gen #(.W(DIV_W)) u_tone (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (tone_en),
      .div  (div),
      .out  (buzz)
   );
endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb_buzzer_arbiter: owner/elapsed-time model of the buzzer arbiter checked every cycle,
// plus hand-computed literal expectations at key cycles of each directed scenario.
module tb_buzzer_arbiter;
   localparam int OWN_NONE = 0, OWN_AL = 1, OWN_CH = 2, OWN_KY = 3;
   logic       clk = 1'b0, rst_n = 1'b1;
   logic       alarm_req = 1'b0, chime_req = 1'b0, key_req = 1'b0, ack = 1'b0;
   logic       buzz, busy;
   logic [2:0] grant;
   int         n_pass = 0, n_total = 0;
   int         m_own = OWN_NONE, m_e = 0;
   logic       m_sil = 1'b0, m_ring, m_fin, key_ok;

   buzzer_arbiter dut (
      .clk(clk), .rst_n(rst_n), .alarm_req(alarm_req), .chime_req(chime_req),
      .key_req(key_req), .ack(ack), .buzz(buzz), .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

`ifdef BUZZER_KEY_CLICK_EN
   assign key_ok = key_req;
`else
   assign key_ok = 1'b0;
`endif
   assign m_ring = alarm_req && !m_sil;
   assign m_fin  = (m_own == OWN_CH && m_e == 5 * 1024 - 1) ||
                   (m_own == OWN_AL && (!alarm_req || ack || m_e == 20 * 1024 - 1)) ||
                   (m_own == OWN_KY && m_e == 31);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_own <= OWN_NONE;
         m_e   <= 0;
         m_sil <= 1'b0;
      end else begin
         m_sil <= !alarm_req ? 1'b0 : (m_own == OWN_AL && (ack || m_e == 20 * 1024 - 1)) ? 1'b1 : m_sil;
         m_e   <= (m_own == OWN_NONE || m_fin || (m_own != OWN_AL && m_ring)) ? 0 : m_e + 1;
         if (m_own == OWN_NONE)
            m_own <= m_ring ? OWN_AL : chime_req ? OWN_CH : key_ok ? OWN_KY : OWN_NONE;
         else if (m_own != OWN_AL && m_ring) m_own <= OWN_AL;
         else if (m_fin) m_own <= OWN_NONE;
      end
   end

   function automatic logic [2:0] f_grant(int own);
      return own == OWN_AL ? 3'b100 : own == OWN_CH ? 3'b010 : own == OWN_KY ? 3'b001 : 3'b000;
   endfunction

   function automatic logic f_buzz(int own, int e);
      if (own == OWN_CH)
         return e < 4096 ? ((e % 1024) < 256 && (((e % 1024) / 4) % 2) == 0)
                         : ((((e % 1024) / 2) % 2) == 0);
      if (own == OWN_AL) return (e % 256) < 128 && ((((e % 256) / 2) % 2) == 0);
      if (own == OWN_KY) return ((e / 2) % 2) == 0;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      chk("model_grant", 32'(grant), 32'(f_grant(m_own)));
      chk("model_buzz", 32'(buzz), 32'(f_buzz(m_own, m_e)));
      chk("model_busy", 32'(busy), 32'(m_own != OWN_NONE));
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      chk("reset_grant", 32'(grant), 0);
      chk("reset_buzz", 32'(buzz), 0);
      chk("reset_busy", 32'(busy), 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      // chime and key together: chime wins, key dropped; key during chime ignored
      chime_req = 1'b1; key_req = 1'b1;
      cyc(1);
      chime_req = 1'b0; key_req = 1'b0;
      chk("chime_c1_grant", 32'(grant), 32'h2);
      chk("chime_c1_buzz", 32'(buzz), 1);
      cyc(4);   chk("chime_c5_buzz", 32'(buzz), 0);
      cyc(4);   chk("chime_c9_buzz", 32'(buzz), 1);
      cyc(91);  key_req = 1'b1;
      cyc(1);   key_req = 1'b0;
      chk("chime_key_ignored", 32'(grant), 32'h2);
      cyc(155); chk("chime_c256_grant", 32'(grant), 32'h2);
      cyc(1);   chk("chime_c257_buzz", 32'(buzz), 0);
      cyc(768); chk("chime_c1025_buzz", 32'(buzz), 1);
      cyc(3072); chk("chime_c4097_buzz", 32'(buzz), 1);
      cyc(2);   chk("chime_c4099_buzz", 32'(buzz), 0);
      cyc(1021); chk("chime_c5120_grant", 32'(grant), 32'h2);
      cyc(1);   chk("chime_c5121_busy", 32'(busy), 0);
      cyc(3);
      // alarm timeout and no re-ring while held
      alarm_req = 1'b1;
      cyc(1);   chk("alarm_c1_grant", 32'(grant), 32'h4);
      chk("alarm_c1_buzz", 32'(buzz), 1);
      cyc(128); chk("alarm_c129_buzz", 32'(buzz), 0);
      cyc(128); chk("alarm_c257_buzz", 32'(buzz), 1);
      cyc(20223); chk("alarm_c20480_grant", 32'(grant), 32'h4);
      cyc(1);   chk("alarm_timeout_grant", 32'(grant), 0);
      cyc(50);  chk("alarm_silenced_grant", 32'(grant), 0);
      alarm_req = 1'b0;
      cyc(3);   alarm_req = 1'b1;
      cyc(1);   chk("alarm_rering_grant", 32'(grant), 32'h4);
      alarm_req = 1'b0;
      cyc(1);   chk("alarm_drop_grant", 32'(grant), 0);
      cyc(3);
      // alarm preempts chime, then ack silences it
      chime_req = 1'b1;
      cyc(1);   chime_req = 1'b0;
      cyc(1999); alarm_req = 1'b1;
      cyc(1);   chk("preempt_grant", 32'(grant), 32'h4);
      chk("preempt_buzz", 32'(buzz), 1);
      cyc(299); ack = 1'b1;
      cyc(1);   ack = 1'b0;
      chk("ack_grant", 32'(grant), 0);
      cyc(100); chk("ack_hold_grant", 32'(grant), 0);
      chk("ack_hold_busy", 32'(busy), 0);
      alarm_req = 1'b0;
      cyc(3);
      // key click
      key_req = 1'b1;
      cyc(1);   key_req = 1'b0;
`ifdef BUZZER_KEY_CLICK_EN
      chk("key_c1_grant", 32'(grant), 32'h1);
      chk("key_c1_buzz", 32'(buzz), 1);
      cyc(2);   chk("key_c3_buzz", 32'(buzz), 0);
      cyc(30);  chk("key_c33_grant", 32'(grant), 0);
`else
      chk("key_off_grant", 32'(grant), 0);
      chk("key_off_buzz", 32'(buzz), 0);
      cyc(32);  chk("key_off_later_grant", 32'(grant), 0);
`endif
      cyc(3);
      // asynchronous reset in the middle of the high beep
      chime_req = 1'b1;
      cyc(1);   chime_req = 1'b0;
      cyc(4096); chk("hi_c4097_buzz", 32'(buzz), 1);
      chk("hi_c4097_grant", 32'(grant), 32'h2);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_buzz", 32'(buzz), 0);
      chk("async_rst_grant", 32'(grant), 0);
      chk("async_rst_busy", 32'(busy), 0);
      cyc(2);   rst_n = 1'b1;
      cyc(20);  chk("post_rst_grant", 32'(grant), 0);
      chk("post_rst_buzz", 32'(buzz), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
